// File: rtl/mem_block_responder_pkg.sv
// Shared cache definitions: word/block geometry and block-transfer FSM encoding.
package mem_block_responder_pkg;

    localparam int DATA_WIDTH     = 16;
    localparam int OFFSET_WIDTH   = 2;
    localparam int DATA_PER_BLOCK = 1 << OFFSET_WIDTH;
    localparam int BLOCK_WIDTH    = DATA_WIDTH * DATA_PER_BLOCK;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } state_e;

    // Word k of a block sits in bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH].
    typedef logic [DATA_PER_BLOCK-1:0][DATA_WIDTH-1:0] block_t;

    function automatic logic is_busy(input state_e s);
        return s != IDLE;
    endfunction

endpackage

// File: rtl/mem_block_responder_if.sv
// Cache-controller <-> main-memory block transfer bundle.
interface mem_block_responder_if
    import mem_block_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 14
);
    logic                   m_rd;
    logic                   m_wr;
    logic [ADDR_WIDTH-1:0]  m_addr;
    logic [BLOCK_WIDTH-1:0] m_blockout;
    logic [BLOCK_WIDTH-1:0] m_blockin;
    logic                   m_ready;
    logic                   busy;

    modport master (
        output m_rd, m_wr, m_addr, m_blockout,
        input  m_blockin, m_ready, busy
    );

    modport slave (
        input  m_rd, m_wr, m_addr, m_blockout,
        output m_blockin, m_ready, busy
    );
endinterface

// File: rtl/mem_block_responder_mem.sv
// Simple word SRAM: asynchronous read, write on rising edge when sel & wr.
module mem #(
    parameter int ADR_WIDTH  = 16,
    parameter int DATA_WIDTH = 16,
    parameter int MEM_SIZE   = 1 << 16
) (
    input  logic                  clk_i,
    input  logic                  sel_i,
    input  logic                  wr_i,
    input  logic [ADR_WIDTH-1:0]  adr_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    output logic [DATA_WIDTH-1:0] dout_o
);
    logic [DATA_WIDTH-1:0] ram [MEM_SIZE];

    always_ff @(posedge clk_i) begin
        if (sel_i && wr_i) ram[adr_i] <= din_i;
    end

    assign dout_o = ram[adr_i];
endmodule

// File: rtl/mem_block_responder.sv
// Main-memory responder: serves block refills / write-backs as four word beats
// after a programmable latency, with a one-cycle ready pulse on completion.
module mem_block_responder
    import mem_block_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int LATENCY    = 4
) (
    input  logic clk,
    input  logic rst,
    mem_block_responder_if.slave bus
);
    localparam int WA_WIDTH  = ADDR_WIDTH + OFFSET_WIDTH;
    localparam int CNT_WIDTH = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] WAIT_LAST =
        (LATENCY > 0) ? CNT_WIDTH'(LATENCY - 1) : '0;
    localparam logic [OFFSET_WIDTH-1:0] BEAT_LAST = OFFSET_WIDTH'(DATA_PER_BLOCK - 1);

    state_e                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    wcnt_q, wcnt_d;
    logic [OFFSET_WIDTH-1:0] beat_q, beat_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    wr_q, wr_d;
    block_t                  buf_q, buf_d;

    logic                    mem_sel;
    logic                    mem_wr;
    logic [WA_WIDTH-1:0]     mem_adr;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            beat_q  <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        buf_d   = buf_q;
        mem_sel = 1'b0;
        mem_wr  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Write wins when both are raised; the read is simply dropped.
                if (bus.m_wr || bus.m_rd) begin
                    addr_d  = bus.m_addr;
                    wr_d    = bus.m_wr;
                    wcnt_d  = '0;
                    beat_d  = '0;
                    if (bus.m_wr) buf_d = block_t'(bus.m_blockout);
                    state_d = (LATENCY == 0) ? XFER : WAIT;
                end
            end
            WAIT: begin
                if (wcnt_q == WAIT_LAST) begin
                    wcnt_d  = '0;
                    beat_d  = '0;
                    state_d = XFER;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            XFER: begin
                // Gating with rst keeps an aborted write-back from landing its current beat.
                mem_sel = ~rst;
                mem_wr  = wr_q;
                if (!wr_q) buf_d[beat_q] = mem_rdata;
                if (beat_q == BEAT_LAST) state_d = DONE;
                else                     beat_d  = beat_q + 1'b1;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem_adr       = {addr_q, beat_q};
    assign bus.m_blockin = buf_q;
    assign bus.m_ready   = (state_q == DONE);
    assign bus.busy      = is_busy(state_q);

    mem #(
        .ADR_WIDTH (WA_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .MEM_SIZE  (1 << WA_WIDTH)
    ) u_mem (
        .clk_i (clk),
        .sel_i (mem_sel),
        .wr_i  (mem_wr),
        .adr_i (mem_adr),
        .din_i (buf_q[beat_q]),
        .dout_o(mem_rdata)
    );
endmodule

// File: tb/tb_mem_block_responder.sv
// Bench for mem_block_responder: default-latency and zero-latency builds side by side.
module tb_mem_block_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_block_responder_if #(.ADDR_WIDTH(14)) bus  ();
    mem_block_responder_if #(.ADDR_WIDTH(14)) bus0 ();

    mem_block_responder #(.ADDR_WIDTH(14), .LATENCY(4)) u_dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );
    mem_block_responder #(.ADDR_WIDTH(14), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave)
    );

    typedef struct {
        bit          use0;
        bit          rd;
        bit          wr;
        bit          glitch;
        logic [13:0] addr;
        logic [63:0] data;
        logic [63:0] exp;
    } txn_t;

    typedef struct {
        logic [63:0] blk;
        int          cyc;
    } sb_t;

    sb_t  sb[$];
    txn_t tbl[14];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit use0, input bit rd, input bit wr,
                         input logic [13:0] a, input logic [63:0] d);
        if (use0) begin
            bus0.m_rd = rd; bus0.m_wr = wr; bus0.m_addr = a; bus0.m_blockout = d;
        end else begin
            bus.m_rd = rd; bus.m_wr = wr; bus.m_addr = a; bus.m_blockout = d;
        end
    endtask

    task automatic run_txn(input txn_t t);
        sb_t e;
        int  got;
        int  nbusy;
        logic rdy, bsy;
        e.blk = t.exp;
        e.cyc = (t.use0 ? 0 : 4) + 5;
        sb.push_back(e);
        @(negedge clk);
        drive(t.use0, t.rd, t.wr, t.addr, t.data);
        got = 0;
        nbusy = 0;
        for (int k = 1; k <= 40 && got == 0; k++) begin
            @(posedge clk); #1;
            if (t.glitch && k == 2) drive(t.use0, t.rd, t.wr, 14'h3FFF, ~t.data);
            bsy = t.use0 ? bus0.busy : bus.busy;
            rdy = t.use0 ? bus0.m_ready : bus.m_ready;
            if (bsy) nbusy++;
            if (rdy) got = k;
        end
        drive(t.use0, 1'b0, 1'b0, '0, '0);
        e = sb.pop_front();
        if (got == 0) begin
            check("ready_timeout", 64'd0, 64'd1);
        end else begin
            check("ready_cycle", 64'(got), 64'(e.cyc));
            check("busy_cycles", 64'(nbusy), 64'(e.cyc));
            check("blockin", t.use0 ? bus0.m_blockin : bus.m_blockin, e.blk);
        end
        @(posedge clk); #1;
        check("ready_pulse_end", 64'(t.use0 ? bus0.m_ready : bus.m_ready), 64'd0);
        check("busy_fall", 64'(t.use0 ? bus0.busy : bus.busy), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic saw_ready;
        tbl[0]  = '{0, 0, 1, 0, 14'h0012, 64'h4444_3333_2222_1111, 64'h4444_3333_2222_1111};
        tbl[1]  = '{0, 1, 0, 0, 14'h0012, 64'h0,                   64'h4444_3333_2222_1111};
        tbl[2]  = '{0, 0, 1, 0, 14'h3FFF, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567};
        tbl[3]  = '{0, 0, 1, 0, 14'h0000, 64'hFFFF_0000_AAAA_5555, 64'hFFFF_0000_AAAA_5555};
        tbl[4]  = '{0, 1, 0, 0, 14'h3FFF, 64'h0,                   64'hDEAD_BEEF_0123_4567};
        tbl[5]  = '{0, 1, 0, 0, 14'h0000, 64'h0,                   64'hFFFF_0000_AAAA_5555};
        tbl[6]  = '{0, 1, 1, 0, 14'h0001, 64'h0BAD_0BAD_1234_5678, 64'h0BAD_0BAD_1234_5678};
        tbl[7]  = '{0, 1, 0, 0, 14'h0001, 64'h0,                   64'h0BAD_0BAD_1234_5678};
        tbl[8]  = '{0, 0, 1, 1, 14'h0020, 64'hCAFE_F00D_55AA_33CC, 64'hCAFE_F00D_55AA_33CC};
        tbl[9]  = '{0, 1, 0, 0, 14'h0020, 64'h0,                   64'hCAFE_F00D_55AA_33CC};
        tbl[10] = '{0, 1, 0, 0, 14'h3FFF, 64'h0,                   64'hDEAD_BEEF_0123_4567};
        tbl[11] = '{0, 0, 1, 0, 14'h0100, 64'h1111_2222_3333_4444, 64'h1111_2222_3333_4444};
        tbl[12] = '{1, 0, 1, 1, 14'h0005, 64'h8765_4321_00FF_7E81, 64'h8765_4321_00FF_7E81};
        tbl[13] = '{1, 1, 0, 0, 14'h0005, 64'h0,                   64'h8765_4321_00FF_7E81};

        drive(0, 0, 0, '0, '0);
        drive(1, 0, 0, '0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;

        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("idle_ready", 64'(bus.m_ready), 64'd0);
            check("idle_busy", 64'(bus.busy), 64'd0);
            check("idle_blockin", bus.m_blockin, 64'd0);
        end
        check("idle_ready0", 64'(bus0.m_ready), 64'd0);
        check("idle_blockin0", bus0.m_blockin, 64'd0);

        for (int i = 0; i < 12; i++) begin
            run_txn(tbl[i]);
            if (i == 1) begin
                check("mem_0048", 64'(u_dut.u_mem.ram[16'h0048]), 64'h1111);
                check("mem_0049", 64'(u_dut.u_mem.ram[16'h0049]), 64'h2222);
                check("mem_004A", 64'(u_dut.u_mem.ram[16'h004A]), 64'h3333);
                check("mem_004B", 64'(u_dut.u_mem.ram[16'h004B]), 64'h4444);
            end
        end

        // Reset lands in XFER beat 2 (cycle 7) of a write-back over tbl[11]'s block.
        @(negedge clk);
        drive(0, 0, 1, 14'h0100, 64'h9999_8888_7777_6666);
        saw_ready = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            if (bus.m_ready) saw_ready = 1'b1;
        end
        rst = 1'b1;
        drive(0, 0, 0, '0, '0);
        @(posedge clk); #1;
        check("rst_no_ready_before", 64'(saw_ready), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_ready", 64'(bus.m_ready), 64'd0);
        check("rst_blockin", bus.m_blockin, 64'd0);
        @(negedge clk); rst = 1'b0;
        check("rst_mem_w0", 64'(u_dut.u_mem.ram[16'h0400]), 64'h6666);
        check("rst_mem_w1", 64'(u_dut.u_mem.ram[16'h0401]), 64'h7777);
        check("rst_mem_w2", 64'(u_dut.u_mem.ram[16'h0402]), 64'h2222);
        check("rst_mem_w3", 64'(u_dut.u_mem.ram[16'h0403]), 64'h1111);
        run_txn('{0, 1, 0, 0, 14'h0100, 64'h0, 64'h1111_2222_7777_6666});

        for (int i = 12; i < 14; i++) run_txn(tbl[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
